uart_rx_deser_gen2: RTL

Parametrised receive-side deserializer for the UART RX path, successor of the fixed 8-bit, prescale-8/16-only deserializer. It sits between the RX FSM / edge-bit counter / data sampler and the parity and stop checkers. It captures a configurable-length data field at any legal prescale, LSB- or MSB-first, into a holding register. It flags frame completion with a one-cycle valid pulse and flags aborted frames.

---
 rtl/uart_rx_pkg.sv | 14 +
 rtl/uart_rx_cap_strobe.sv | 50 +++++
 rtl/uart_rx_deser_gen2.sv | 109 ++++++++++
 3 files changed

// File: rtl/uart_rx_pkg.sv
// Shared definitions for the UART RX deserializer path and its sibling
// checkers: FSM state encoding and minimum legal configuration values.
package uart_rx_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } deser_state_e;

  localparam int MIN_PRESCALE = 4;
  localparam int MIN_DATA_LEN = 5;

endpackage

// File: rtl/uart_rx_cap_strobe.sv
// Frame-configuration register plus the per-bit capture strobe. On the load
// cycle the incoming configuration is used directly, so the first bit is not lost.
module uart_rx_cap_strobe
  import uart_rx_pkg::*;
#(
  parameter int DATA_WIDTH     = 8,
  parameter int PRESCALE_WIDTH = 6
) (
  input  logic                      CLK_DESER,
  input  logic                      RST_DESER,
  input  logic                      load,
  input  logic                      deser_en,
  input  logic [PRESCALE_WIDTH-1:0] Prescale,
  input  logic [PRESCALE_WIDTH-1:0] edge_cnt,
  input  logic [3:0]                data_len,
  input  logic                      lsb_first,
  output logic                      cap,
  output logic [3:0]                cfg_len,
  output logic                      cfg_lsb,
  output logic                      cfg_illegal
);

  logic [PRESCALE_WIDTH-1:0] prescale_q;
  logic [3:0]                len_q;
  logic                      lsb_q;
  logic [PRESCALE_WIDTH-1:0] presc_eff;

  // NOTE: sequential state is written with non-blocking assignments only.
  always_ff @(posedge CLK_DESER or posedge RST_DESER) begin
    if (RST_DESER) begin
      prescale_q <= '0;
      len_q      <= '0;
      lsb_q      <= 1'b0;
    end else if (load) begin
      prescale_q <= Prescale;
      len_q      <= data_len;
      lsb_q      <= lsb_first;
    end
  end

  assign presc_eff   = load ? Prescale  : prescale_q;
  assign cfg_len     = load ? data_len  : len_q;
  assign cfg_lsb     = load ? lsb_first : lsb_q;

  assign cap         = deser_en && (edge_cnt == presc_eff - PRESCALE_WIDTH'(1));
  assign cfg_illegal = (presc_eff < PRESCALE_WIDTH'(MIN_PRESCALE))
                    || (cfg_len < 4'(MIN_DATA_LEN))
                    || ({1'b0, cfg_len} > 5'(DATA_WIDTH));

endmodule

// File: rtl/uart_rx_deser_gen2.sv
// Parametrised UART RX deserializer: collects data_len bits at the last
// oversample edge of each bit, LSB- or MSB-first, and publishes the word.
module uart_rx_deser_gen2
  import uart_rx_pkg::*;
#(
  parameter int DATA_WIDTH     = 8,
  parameter int PRESCALE_WIDTH = 6
) (
  input  logic                      CLK_DESER,
  input  logic                      RST_DESER,
  input  logic                      deser_en,
  input  logic [PRESCALE_WIDTH-1:0] Prescale,
  input  logic [PRESCALE_WIDTH-1:0] edge_cnt,
  input  logic                      sampled_bit,
  input  logic [3:0]                data_len,
  input  logic                      lsb_first,
  output logic [DATA_WIDTH-1:0]     P_DATA,
  output logic                      data_valid,
  output logic                      deser_busy,
  output logic                      deser_abort,
  output logic                      cfg_err
);

  localparam int CNT_W = $clog2(DATA_WIDTH + 1);

  deser_state_e          state, state_nxt;
  logic [DATA_WIDTH-1:0] shreg, shreg_nxt, shreg_base;
  logic [CNT_W-1:0]      bit_cnt, bit_cnt_nxt, cnt_base;
  logic                  start, take, complete, abort_nxt;
  logic                  cap, cfg_lsb, cfg_illegal;
  logic [3:0]            cfg_len;

  assign start = (state == IDLE) && deser_en;

  uart_rx_cap_strobe #(
    .DATA_WIDTH    (DATA_WIDTH),
    .PRESCALE_WIDTH(PRESCALE_WIDTH)
  ) u_cap_strobe (
    .CLK_DESER  (CLK_DESER),
    .RST_DESER  (RST_DESER),
    .load       (start),
    .deser_en   (deser_en),
    .Prescale   (Prescale),
    .edge_cnt   (edge_cnt),
    .data_len   (data_len),
    .lsb_first  (lsb_first),
    .cap        (cap),
    .cfg_len    (cfg_len),
    .cfg_lsb    (cfg_lsb),
    .cfg_illegal(cfg_illegal)
  );

  // NOTE: every output of this block gets a default first, so no latch is inferred.
  always_comb begin
    state_nxt   = state;
    shreg_base  = start ? '0 : shreg;
    cnt_base    = start ? '0 : bit_cnt;
    shreg_nxt   = shreg_base;
    bit_cnt_nxt = cnt_base;
    complete    = 1'b0;
    abort_nxt   = 1'b0;
    take        = cap && !cfg_illegal && (state != DONE);

    case (state)
      IDLE:    if (deser_en) state_nxt = SHIFT;
      SHIFT:   if (!deser_en) begin
                 state_nxt = IDLE;
                 abort_nxt = 1'b1;
               end
      DONE:    if (!deser_en) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase

    // The start cycle works from a cleared word/count so its bit is kept.
    if (take) begin
      if (cfg_lsb) shreg_nxt = shreg_base | (DATA_WIDTH'(sampled_bit) << cnt_base);
      else         shreg_nxt = {shreg_base[DATA_WIDTH-2:0], sampled_bit};
      bit_cnt_nxt = cnt_base + CNT_W'(1);
      if (bit_cnt_nxt == CNT_W'(cfg_len)) begin
        complete  = 1'b1;
        state_nxt = DONE;
      end
    end
  end

  // NOTE: the shift register is reset too, so an interrupted frame leaves no residue.
  always_ff @(posedge CLK_DESER or posedge RST_DESER) begin
    if (RST_DESER) begin
      state       <= IDLE;
      shreg       <= '0;
      bit_cnt     <= '0;
      P_DATA      <= '0;
      data_valid  <= 1'b0;
      deser_busy  <= 1'b0;
      deser_abort <= 1'b0;
      cfg_err     <= 1'b0;
    end else begin
      state       <= state_nxt;
      shreg       <= shreg_nxt;
      bit_cnt     <= bit_cnt_nxt;
      data_valid  <= complete;
      deser_abort <= abort_nxt;
      deser_busy  <= (state == SHIFT);
      if (start)    cfg_err <= cfg_illegal;
      if (complete) P_DATA  <= shreg_nxt;
    end
  end

endmodule
